// File: rtl/end_sm.sv
// rtl/end_sm.sv - game-over message controller: hold, optional blink, clean restart.
// Optional blink logic is compiled in when END_BLINK_EN is defined.
module end_sm #(
    parameter int HOLD_FRAMES  = 60,
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic startOfFrame,
    input  logic game_over,
    input  logic win,
    input  logic restart_key,
    input  logic drawing_request_win,
    input  logic drawing_request_lose,
    output logic endMessage_DR,
    output logic end_active,
    output logic restart_pulse
);

    localparam logic [2:0] s_play    = 3'd0;
    localparam logic [2:0] s_hold    = 3'd1;
    localparam logic [2:0] s_arm     = 3'd2;
    localparam logic [2:0] s_wait    = 3'd3;
    localparam logic [2:0] s_restart = 3'd4;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

    logic [2:0] state_q, state_d;
    logic       go_prev_q;
    logic       win_l_q, win_l_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       rise;
    logic       msg_state;
    logic       phase;

    assign rise      = game_over & ~go_prev_q;
    assign msg_state = (state_q == s_hold) || (state_q == s_arm) || (state_q == s_wait);

    always_comb begin
        state_d    = state_q;
        win_l_d    = win_l_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            s_play: begin
                if (rise) begin
                    win_l_d    = win;
                    hold_cnt_d = 8'd0;
                    state_d    = s_hold;
                end
            end
            s_hold: begin
                if (startOfFrame) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                    if (hold_cnt_q == HOLD_LAST) state_d = s_arm;
                end
            end
            // A key still held when the hold expires must be released first.
            s_arm:     if (!restart_key) state_d = s_wait;
            s_wait:    if (restart_key)  state_d = s_restart;
            s_restart: state_d = s_play;
            default:   state_d = s_play;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= s_play;
            go_prev_q  <= 1'b1;
            win_l_q    <= 1'b0;
            hold_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            go_prev_q  <= game_over;
            win_l_q    <= win_l_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

`ifdef END_BLINK_EN
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       phase_q, phase_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if ((state_q == s_play) && rise) begin
            blink_cnt_d = 8'd0;
            phase_d     = 1'b1;
        end else if (msg_state && startOfFrame) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = 8'd0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= 8'd0;
            phase_q     <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign phase = phase_q;
`else
    localparam int blink_frames_unused = BLINK_FRAMES;

    assign phase = 1'b1;
`endif

    assign end_active    = (state_q != s_play);
    assign restart_pulse = (state_q == s_restart);
    assign endMessage_DR = msg_state & phase &
                           (win_l_q ? drawing_request_win : drawing_request_lose);

endmodule

// File: tb/tb_end_sm.sv
// tb/tb_end_sm.sv - scoreboard bench for end_sm with HOLD_FRAMES=3, BLINK_FRAMES=2.
module tb_end_sm;

    logic clk = 1'b0;
    logic reset, sof, go, win, key, drw, drl;
    logic dr, act, pulse;

    int checks   = 0;
    int failures = 0;

    // Scoreboard entry: {check_dr, dr, end_active, restart_pulse}
    logic [3:0] exp_q[$];
    logic [3:0] e;

    end_sm #(.HOLD_FRAMES(3), .BLINK_FRAMES(2)) dut (
        .clk                 (clk),
        .reset               (reset),
        .startOfFrame        (sof),
        .game_over           (go),
        .win                 (win),
        .restart_key         (key),
        .drawing_request_win (drw),
        .drawing_request_lose(drl),
        .endMessage_DR       (dr),
        .end_active          (act),
        .restart_pulse       (pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic ph(int k);
`ifdef END_BLINK_EN
        return ((k / 2) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic test_reset;
        reset = 1'b1; sof = 0; go = 0; win = 0; key = 0; drw = 1; drl = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) reset = 1'b0;
            exp_q.push_back(4'b1_0_00);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({act, pulse} !== e[1:0]) begin
                failures++;
                $display("FAIL reset_state cyc=%0d act_pulse got=%b exp=%b", i, {act, pulse}, e[1:0]);
            end
            checks++;
            if (dr !== e[2]) begin
                failures++;
                $display("FAIL reset_dr cyc=%0d got=%b exp=%b", i, dr, e[2]);
            end
        end
    endtask

    task automatic test_lose_select;
        drw = 0; drl = 1; win = 0; go = 1;
        exp_q.push_back(4'b1_1_10);
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({dr, act, pulse} !== e[2:0]) begin
            failures++;
            $display("FAIL lose_entry dr_act_pulse got=%b exp=%b", {dr, act, pulse}, e[2:0]);
        end
        drw = 1; drl = 0;
        exp_q.push_back(4'b1_0_10);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({dr, act, pulse} !== e[2:0]) begin
            failures++;
            $display("FAIL lose_bitmap dr_act_pulse got=%b exp=%b", {dr, act, pulse}, e[2:0]);
        end
        drw = 0; drl = 0;
    endtask

    task automatic test_hold_key;
        bit sof_t [11] = '{0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0};
        bit key_t [11] = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 1, 1};
        bit act_t [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        bit pul_t [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 11; i++) begin
            sof = sof_t[i]; key = key_t[i];
            exp_q.push_back({1'b1, 1'b0, act_t[i], pul_t[i]});
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({dr, act, pulse} !== e[2:0]) begin
                failures++;
                $display("FAIL hold_key cyc=%0d dr_act_pulse got=%b exp=%b", i, {dr, act, pulse}, e[2:0]);
            end
        end
        sof = 0; key = 0;
    endtask

    task automatic test_edge_with_key;
        bit go_t  [2] = '{0, 1};
        bit act_t [2] = '{0, 1};
        for (int i = 0; i < 2; i++) begin
            go = go_t[i]; key = go_t[i]; win = 1;
            exp_q.push_back({1'b1, 1'b0, act_t[i], 1'b0});
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({dr, act, pulse} !== e[2:0]) begin
                failures++;
                $display("FAIL edge_key cyc=%0d dr_act_pulse got=%b exp=%b", i, {dr, act, pulse}, e[2:0]);
            end
        end
        win = 0; drw = 1; drl = 0;
        exp_q.push_back(4'b1_1_10);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (dr !== e[2]) begin
            failures++;
            $display("FAIL win_bitmap dr got=%b exp=%b", dr, e[2]);
        end
        drw = 0;
    endtask

    task automatic test_key_held;
        bit sof_t [14] = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        bit key_t [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
        bit act_t [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        bit pul_t [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 14; i++) begin
            sof = sof_t[i]; key = key_t[i];
            exp_q.push_back({1'b1, 1'b0, act_t[i], pul_t[i]});
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({dr, act, pulse} !== e[2:0]) begin
                failures++;
                $display("FAIL key_held cyc=%0d dr_act_pulse got=%b exp=%b", i, {dr, act, pulse}, e[2:0]);
            end
        end
        sof = 0; key = 0;
    endtask

    task automatic test_blink;
        go = 0; key = 0; win = 0; drw = 1; drl = 1;
        exp_q.push_back(4'b1_0_00);
        tick();
        go = 1;
        exp_q.push_back({1'b1, ph(0), 2'b10});
        tick();
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            if (i == 1) begin
                checks++;
                if ({dr, act, pulse} !== e[2:0]) begin
                    failures++;
                    $display("FAIL blink_entry dr_act_pulse got=%b exp=%b", {dr, act, pulse}, e[2:0]);
                end
            end
        end
        for (int k = 0; k < 10; k++) begin
            for (int s = 0; s < 2; s++) begin
                sof = (s == 1);
                exp_q.push_back({1'b1, ph(k + s), 2'b10});
                tick();
                e = exp_q.pop_front();
                checks++;
                if ({dr, act, pulse} !== e[2:0]) begin
                    failures++;
                    $display("FAIL blink frame=%0d sub=%0d dr_act_pulse got=%b exp=%b", k, s, {dr, act, pulse}, e[2:0]);
                end
            end
        end
        sof = 0;
    endtask

    task automatic test_reset_mid;
        bit go_t  [4] = '{1, 1, 0, 1};
        bit dr_t  [4] = '{0, 0, 0, 1};
        bit act_t [4] = '{0, 0, 0, 1};
        drw = 1; drl = 1;
        reset = 1'b1;
        exp_q.push_back(4'b1_0_00);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({dr, act, pulse} !== e[2:0]) begin
            failures++;
            $display("FAIL reset_async dr_act_pulse got=%b exp=%b", {dr, act, pulse}, e[2:0]);
        end
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            go = go_t[i];
            exp_q.push_back({1'b1, dr_t[i], act_t[i], 1'b0});
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({dr, act, pulse} !== e[2:0]) begin
                failures++;
                $display("FAIL reset_release cyc=%0d dr_act_pulse got=%b exp=%b", i, {dr, act, pulse}, e[2:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lose_select();
        test_hold_key();
        test_edge_with_key();
        test_key_held();
        test_blink();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
